// File: rtl/mem_interleaved_arbiter_pkg.sv
// Shared definitions for the two-requester interleaved memory arbiter.
//   DefaultM / DefaultK : default data width and requester address width
//   CntW                : width of the optional statistics counters
//   prio_e              : conflict-priority FSM state
//   sat_inc             : saturating increment for the statistics counters
package mem_interleaved_arbiter_pkg;

  localparam int unsigned DefaultM = 8;
  localparam int unsigned DefaultK = 11;
  localparam int unsigned CntW     = 16;

  typedef enum logic {
    PRIO0 = 1'b0,
    PRIO1 = 1'b1
  } prio_e;

  function automatic logic [CntW-1:0] sat_inc(input logic [CntW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/mem_arb_read_return.sv
// Per-requester read-return stage: captures the selected bank read data on a
// granted read and flags it valid for exactly one cycle.
//   clk_i      : clock
//   rst_ni     : asynchronous active-low reset
//   capture_i  : granted read this cycle
//   bank_rd_i  : read data from the bank the requester is accessing
//   rd_o       : registered read data, held until the next granted read
//   rvalid_o   : rd_o valid, one cycle after the grant
module mem_arb_read_return #(
  parameter int unsigned M = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         capture_i,
  input  logic [M-1:0] bank_rd_i,
  output logic [M-1:0] rd_o,
  output logic         rvalid_o
);

  logic [M-1:0] rd_q;
  logic         rvalid_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_q     <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= capture_i;
      if (capture_i) begin
        rd_q <= bank_rd_i;
      end
    end
  end

  assign rd_o     = rd_q;
  assign rvalid_o = rvalid_q;

endmodule

// File: rtl/mem_interleaved_arbiter.sv
// Two-requester arbiter in front of a 2-way interleaved memory. Bank 0 holds
// even addresses, bank 1 odd ones. Requests to different banks are granted
// together; same-bank conflicts are served round-robin.
//   clock, reset_n            : clock, asynchronous active-low reset
//   req/we/addr/wd{0,1}       : requester request, write flag, address, data
//   ack{0,1}                  : combinational grant (same cycle as bank access)
//   rd/rvalid{0,1}            : registered read data and one-cycle valid
//   b{0,1}_we/addr/wd         : bank write enable, address (addr[K-1:1]), data
//   b{0,1}_rd                 : bank combinational read data
// Optional: define MEM_ARB_STATS_EN to add saturating conflict_cnt / dual_cnt.
module mem_interleaved_arbiter
  import mem_interleaved_arbiter_pkg::*;
#(
  parameter int unsigned M = DefaultM,
  parameter int unsigned K = DefaultK
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            req0,
  input  logic            we0,
  input  logic [K-1:0]    addr0,
  input  logic [M-1:0]    wd0,
  output logic            ack0,
  output logic [M-1:0]    rd0,
  output logic            rvalid0,
  input  logic            req1,
  input  logic            we1,
  input  logic [K-1:0]    addr1,
  input  logic [M-1:0]    wd1,
  output logic            ack1,
  output logic [M-1:0]    rd1,
  output logic            rvalid1,
  output logic            b0_we,
  output logic [K-2:0]    b0_addr,
  output logic [M-1:0]    b0_wd,
  input  logic [M-1:0]    b0_rd,
  output logic            b1_we,
  output logic [K-2:0]    b1_addr,
  output logic [M-1:0]    b1_wd,
  input  logic [M-1:0]    b1_rd
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [CntW-1:0] conflict_cnt,
  output logic [CntW-1:0] dual_cnt
`endif
);

  prio_e        prio_q, prio_d;
  logic         conflict;
  logic         grant0, grant1;
  logic         capture0, capture1;
  logic [M-1:0] sel_rd0, sel_rd1;

  // Grants are forced low while reset is asserted so no bank is touched.
  always_comb begin
    conflict = req0 & req1 & (addr0[0] == addr1[0]);
    grant0   = reset_n & req0 & (~conflict | (prio_q == PRIO0));
    grant1   = reset_n & req1 & (~conflict | (prio_q == PRIO1));
    prio_d   = prio_q;
    // A conflict always goes to the holder, so the loser wins next time.
    if (conflict) begin
      prio_d = (prio_q == PRIO0) ? PRIO1 : PRIO0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prio_q <= PRIO0;
    end else begin
      prio_q <= prio_d;
    end
  end

  assign ack0 = grant0;
  assign ack1 = grant1;

  // Both grants never target the same bank, so the two routings are disjoint.
  always_comb begin
    b0_we   = 1'b0;
    b0_addr = '0;
    b0_wd   = '0;
    b1_we   = 1'b0;
    b1_addr = '0;
    b1_wd   = '0;
    if (grant0) begin
      if (addr0[0]) begin
        b1_we   = we0;
        b1_addr = addr0[K-1:1];
        b1_wd   = wd0;
      end else begin
        b0_we   = we0;
        b0_addr = addr0[K-1:1];
        b0_wd   = wd0;
      end
    end
    if (grant1) begin
      if (addr1[0]) begin
        b1_we   = we1;
        b1_addr = addr1[K-1:1];
        b1_wd   = wd1;
      end else begin
        b0_we   = we1;
        b0_addr = addr1[K-1:1];
        b0_wd   = wd1;
      end
    end
  end

  always_comb begin
    capture0 = grant0 & ~we0;
    capture1 = grant1 & ~we1;
    sel_rd0  = addr0[0] ? b1_rd : b0_rd;
    sel_rd1  = addr1[0] ? b1_rd : b0_rd;
  end

  mem_arb_read_return #(
    .M (M)
  ) u_ret0 (
    .clk_i     (clock),
    .rst_ni    (reset_n),
    .capture_i (capture0),
    .bank_rd_i (sel_rd0),
    .rd_o      (rd0),
    .rvalid_o  (rvalid0)
  );

  mem_arb_read_return #(
    .M (M)
  ) u_ret1 (
    .clk_i     (clock),
    .rst_ni    (reset_n),
    .capture_i (capture1),
    .bank_rd_i (sel_rd1),
    .rd_o      (rd1),
    .rvalid_o  (rvalid1)
  );

`ifdef MEM_ARB_STATS_EN
  logic [CntW-1:0] conflict_q, dual_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      conflict_q <= '0;
      dual_q     <= '0;
    end else begin
      if (conflict) begin
        conflict_q <= sat_inc(conflict_q);
      end
      if (grant0 & grant1) begin
        dual_q <= sat_inc(dual_q);
      end
    end
  end

  assign conflict_cnt = conflict_q;
  assign dual_cnt     = dual_q;
`endif

endmodule

// File: tb/tb_mem_interleaved_arbiter.sv
// Randomised bench for mem_interleaved_arbiter with a flat-memory reference
// model, plus directed opening cycles whose outcomes are hand-computed.
module tb_mem_interleaved_arbiter;

  localparam int unsigned M = 8;
  localparam int unsigned K = 11;

  logic         clock = 1'b0;
  logic         reset_n;
  logic         req0, we0, req1, we1;
  logic [K-1:0] addr0, addr1;
  logic [M-1:0] wd0, wd1;
  logic         ack0, ack1, rvalid0, rvalid1;
  logic [M-1:0] rd0, rd1;
  logic         b0_we, b1_we;
  logic [K-2:0] b0_addr, b1_addr;
  logic [M-1:0] b0_wd, b1_wd, b0_rd, b1_rd;
`ifdef MEM_ARB_STATS_EN
  logic [15:0]  conflict_cnt, dual_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  mem_interleaved_arbiter #(
    .M (M),
    .K (K)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .req0    (req0),
    .we0     (we0),
    .addr0   (addr0),
    .wd0     (wd0),
    .ack0    (ack0),
    .rd0     (rd0),
    .rvalid0 (rvalid0),
    .req1    (req1),
    .we1     (we1),
    .addr1   (addr1),
    .wd1     (wd1),
    .ack1    (ack1),
    .rd1     (rd1),
    .rvalid1 (rvalid1),
    .b0_we   (b0_we),
    .b0_addr (b0_addr),
    .b0_wd   (b0_wd),
    .b0_rd   (b0_rd),
    .b1_we   (b1_we),
    .b1_addr (b1_addr),
    .b1_wd   (b1_wd),
    .b1_rd   (b1_rd)
`ifdef MEM_ARB_STATS_EN
    ,
    .conflict_cnt (conflict_cnt),
    .dual_cnt     (dual_cnt)
`endif
  );

  // Bank environment: combinational read, write at the clock edge. Cells
  // never written return a fixed pattern derived from bank and bank address.
  bit [7:0] bm0 [1024];
  bit [7:0] bm1 [1024];
  bit       bw0 [1024];
  bit       bw1 [1024];

  function automatic bit [7:0] bank_init(input bit b, input bit [9:0] x);
    return {x[6:0], b} ^ 8'h5A;
  endfunction

  assign b0_rd = bw0[b0_addr] ? bm0[b0_addr] : bank_init(1'b0, b0_addr);
  assign b1_rd = bw1[b1_addr] ? bm1[b1_addr] : bank_init(1'b1, b1_addr);

  always @(posedge clock) begin
    if (b0_we) begin
      bm0[b0_addr] <= b0_wd;
      bw0[b0_addr] <= 1'b1;
    end
    if (b1_we) begin
      bm1[b1_addr] <= b1_wd;
      bw1[b1_addr] <= 1'b1;
    end
  end

  // Reference model: one flat memory indexed by the full requester address.
  bit [7:0] fm [2048];
  bit       fw [2048];

  function automatic bit [7:0] flat_read(input bit [10:0] a);
    return fw[a] ? fm[a] : (a[7:0] ^ 8'h5A);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", name, got, exp, $time);
    end
  endtask

  // Compare process: checks every cycle at the falling edge, then advances
  // the model to what the next rising edge must produce.
  initial begin : compare
    int          cyc;
    bit          p1;
    bit          ev0, ev1;
    bit [7:0]    erd0, erd1;
    int unsigned ccnt, dcnt;
    bit          conf, eg0, eg1;
    bit          ewe   [2];
    bit [9:0]    eaddr [2];
    bit [7:0]    ewd   [2];
    cyc  = 0;
    p1   = 1'b0;
    ev0  = 1'b0;
    ev1  = 1'b0;
    erd0 = '0;
    erd1 = '0;
    ccnt = 0;
    dcnt = 0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        chk("rst_ack0", ack0, 0);
        chk("rst_ack1", ack1, 0);
        chk("rst_b0", {b0_we, b0_addr, b0_wd}, 0);
        chk("rst_b1", {b1_we, b1_addr, b1_wd}, 0);
        chk("rst_rvalid0", rvalid0, 0);
        chk("rst_rvalid1", rvalid1, 0);
        chk("rst_rd0", rd0, 0);
        chk("rst_rd1", rd1, 0);
`ifdef MEM_ARB_STATS_EN
        chk("rst_conflict_cnt", conflict_cnt, 0);
        chk("rst_dual_cnt", dual_cnt, 0);
`endif
        p1   = 1'b0;
        ev0  = 1'b0;
        ev1  = 1'b0;
        erd0 = '0;
        erd1 = '0;
        ccnt = 0;
        dcnt = 0;
      end else begin
        conf = req0 && req1 && (addr0[0] == addr1[0]);
        eg0  = req0 && !(conf && p1);
        eg1  = req1 && !(conf && !p1);
        for (int b = 0; b < 2; b++) begin
          ewe[b]   = 1'b0;
          eaddr[b] = '0;
          ewd[b]   = '0;
          if (eg0 && (int'(addr0[0]) == b)) begin
            ewe[b] = we0; eaddr[b] = addr0[10:1]; ewd[b] = wd0;
          end
          if (eg1 && (int'(addr1[0]) == b)) begin
            ewe[b] = we1; eaddr[b] = addr1[10:1]; ewd[b] = wd1;
          end
        end
        chk("ack0", ack0, eg0);
        chk("ack1", ack1, eg1);
        chk("b0_bus", {b0_we, b0_addr, b0_wd}, {ewe[0], eaddr[0], ewd[0]});
        chk("b1_bus", {b1_we, b1_addr, b1_wd}, {ewe[1], eaddr[1], ewd[1]});
        chk("rvalid0", rvalid0, ev0);
        chk("rvalid1", rvalid1, ev1);
        chk("rd0", rd0, erd0);
        chk("rd1", rd1, erd1);
`ifdef MEM_ARB_STATS_EN
        chk("conflict_cnt", conflict_cnt, ccnt);
        chk("dual_cnt", dual_cnt, dcnt);
`endif
        // Hand-computed expectations for the directed opening cycles.
        if (cyc == 2) begin
          chk("lit_wr_ack0", ack0, 1);
          chk("lit_wr_b0_we", b0_we, 1);
          chk("lit_wr_b0_addr", b0_addr, 10'h002);
        end
        if (cyc == 4) begin
          chk("lit_rd_rvalid0", rvalid0, 1);
          chk("lit_rd_rd0", rd0, 8'hA5);
          chk("lit_dual_acks", {ack0, ack1}, 2'b11);
        end
        if (cyc == 5) begin
          chk("lit_dual_rvalids", {rvalid0, rvalid1}, 2'b11);
          chk("lit_dual_rd1", rd1, 8'h5F);
          chk("lit_conf_c0", {ack0, ack1}, 2'b10);
        end
        if (cyc == 6) chk("lit_conf_c1", {ack0, ack1}, 2'b01);
        if (cyc >= 7 && cyc <= 12) begin
          chk("lit_alternate", {ack0, ack1}, ((cyc - 7) % 2 == 0) ? 2'b10 : 2'b01);
        end
        if (cyc == 13) chk("lit_pre_rst_ack0", ack0, 1);
        if (cyc == 15) begin
          chk("lit_post_rst_rvalid0", rvalid0, 0);
          chk("lit_post_rst_rd0", rd0, 0);
        end
        if (cyc == 16) chk("lit_post_rst_prio0", {ack0, ack1}, 2'b10);

        // Advance the model: reads see memory before this cycle's writes.
        ev0 = eg0 && !we0;
        ev1 = eg1 && !we1;
        if (ev0) erd0 = flat_read(addr0);
        if (ev1) erd1 = flat_read(addr1);
        if (eg0 && we0) begin fm[addr0] = wd0; fw[addr0] = 1'b1; end
        if (eg1 && we1) begin fm[addr1] = wd1; fw[addr1] = 1'b1; end
        if (conf) p1 = !p1;
        if (conf && ccnt < 32'hFFFF) ccnt++;
        if (eg0 && eg1 && dcnt < 32'hFFFF) dcnt++;
      end
      cyc++;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_in(input bit r0, input bit w0, input bit [10:0] a0, input bit [7:0] d0,
                        input bit r1, input bit w1, input bit [10:0] a1, input bit [7:0] d1);
    req0 = r0; we0 = w0; addr0 = a0; wd0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wd1 = d1;
  endtask

  function automatic bit [10:0] rand_addr();
    return ($urandom_range(0, 3) == 0) ? 11'($urandom_range(0, 2047)) : 11'($urandom_range(0, 15));
  endfunction

  initial begin : stimulus
    bit pa0, pa1;
    reset_n = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    step();                                                  // cycle 0
    step();                                                  // cycle 1
    step(); reset_n = 1'b1;
    set_in(1, 1, 11'h004, 8'hA5, 0, 0, 0, 0);                // cycle 2: write
    step(); set_in(1, 0, 11'h004, 0, 0, 0, 0, 0);            // cycle 3: read back
    step(); set_in(1, 0, 11'h004, 0, 1, 0, 11'h005, 0);      // cycle 4: dual read
    for (int i = 0; i < 2; i++) begin                        // cycles 5-6: conflict
      step(); set_in(1, 0, 11'h003, 0, 1, 0, 11'h007, 0);
    end
    for (int i = 0; i < 6; i++) begin                        // cycles 7-12
      step(); set_in(1, 0, 11'h00B, 0, 1, 0, 11'h00D, 0);
    end
    step(); set_in(1, 0, 11'h004, 0, 0, 0, 0, 0);            // cycle 13: read
    step(); set_in(0, 0, 0, 0, 0, 0, 0, 0);                  // cycle 14: reset pulse
    #3 reset_n = 1'b0;
    #2 reset_n = 1'b1;
    step();                                                  // cycle 15
    step(); set_in(1, 1, 11'h002, 8'h11, 1, 1, 11'h006, 8'h22);  // cycle 16
    step(); set_in(0, 0, 0, 0, 0, 0, 0, 0);

    for (int n = 0; n < 3000; n++) begin
      @(negedge clock);
      #1;
      pa0 = ack0;
      pa1 = ack1;
      step();
      if (req0 && !pa0 && $urandom_range(0, 15) != 0) begin
        // hold the pending request
      end else if ($urandom_range(0, 9) < 6) begin
        req0 = 1'b1; we0 = $urandom_range(0, 1) == 1; addr0 = rand_addr();
        wd0 = 8'($urandom);
      end else begin
        req0 = 1'b0;
      end
      if (req1 && !pa1 && $urandom_range(0, 15) != 0) begin
        // hold the pending request
      end else if ($urandom_range(0, 9) < 6) begin
        req1 = 1'b1; we1 = $urandom_range(0, 1) == 1; addr1 = rand_addr();
        wd1 = 8'($urandom);
      end else begin
        req1 = 1'b0;
      end
      if (n == 1500) begin
        #3 reset_n = 1'b0;
        #2 reset_n = 1'b1;
      end
    end
    @(negedge clock);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, time=%0t limit=1000000", $time);
    $fatal(1);
  end

endmodule
